// File: rtl/bcd_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : bcd_pkg
// Purpose  : Shared types, constants and helpers for the BCD-to-binary
//            converter (FSM state encoding, nibble width, digit validity).
// Revision : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    // Width of one packed BCD digit.
    localparam int BCD_NIBBLE = 4;

    // Widest operand the validity helper can inspect, in digits.
    localparam int MAX_DIGITS = 16;

    // Converter FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    // True when any nibble of the (zero-extended) operand is above 9.
    // Callers widen their operand to the full width; the zero padding
    // nibbles are always legal, so they never trigger a false error.
    function automatic logic has_bad_nibble(
        input logic [BCD_NIBBLE*MAX_DIGITS-1:0] vec
    );
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (vec[i*BCD_NIBBLE +: BCD_NIBBLE] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_to_bin_mul10_add.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mul10_add
// Purpose  : One Horner step: result = acc*10 + digit, modulo 2^OUT_W.
//            The multiply is built from two shifts so no multiplier is
//            needed.
// Revision : 1.0 - initial release
// ============================================================================
module mul10_add
    import bcd_pkg::*;
#(
    parameter int OUT_W = 16
) (
    input  logic [OUT_W-1:0]      acc,
    input  logic [BCD_NIBBLE-1:0] digit,
    output logic [OUT_W-1:0]      result
);

    // acc*10 = acc*8 + acc*2; all terms truncated to OUT_W bits.
    assign result = (acc << 3) + (acc << 1) + OUT_W'(digit);

endmodule
`default_nettype wire

// File: rtl/bcd_to_bin.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : bcd_to_bin
// Purpose  : Sequential packed-BCD to binary converter. Consumes one decimal
//            digit per clock (most significant first) using a multiply-by-ten
//            and add loop, behind a start/busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_to_bin
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int OUT_W  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [BCD_NIBBLE*DIGITS-1:0] bcd_in,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [OUT_W-1:0]             bin_out
);

    localparam int SHIFT_W = BCD_NIBBLE * DIGITS;
    // A single-digit converter still needs a one-bit counter to be legal.
    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [SHIFT_W-1:0]    r_shift;
    logic [OUT_W-1:0]      r_acc;
    logic [OUT_W-1:0]      w_acc_next;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_err;
    logic [OUT_W-1:0]      r_bin;
    logic                  w_bad;
    logic                  w_last;
    logic [BCD_NIBBLE-1:0] w_digit;

    // Operand validity is judged on the live input; it only matters on the
    // accept edge, where it is captured into r_err.
    assign w_bad   = has_bad_nibble((BCD_NIBBLE*MAX_DIGITS)'(bcd_in));
    assign w_digit = r_shift[SHIFT_W-1 -: BCD_NIBBLE];
    assign w_last  = (r_cnt == LAST_CNT);

    mul10_add #(
        .OUT_W (OUT_W)
    ) u_mul10_add (
        .acc    (r_acc),
        .digit  (w_digit),
        .result (w_acc_next)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and state-decoded (Moore) handshake outputs.
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = w_bad ? DONE : CONV;
                end
            end
            CONV: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Datapath: operand capture on accept, one Horner step per CONV cycle,
    // result/err registers that hold between completions.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_bin   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_shift <= bcd_in;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_err   <= w_bad;
                        if (w_bad) begin
                            r_bin <= '0;
                        end
                    end
                end
                CONV: begin
                    r_acc   <= w_acc_next;
                    r_shift <= r_shift << BCD_NIBBLE;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_bin <= w_acc_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign err     = r_err;
    assign bin_out = r_bin;

endmodule
`default_nettype wire

// File: doc/bcd_to_bin.md
# bcd_to_bin

Sequential decimal-to-binary converter: takes a packed BCD value (one 4-bit decimal digit per nibble, most significant digit in the top nibble) and produces its binary equivalent. It uses a Horner multiply-by-ten-and-add loop, one digit per clock. It performs the inverse of the binary-to-decimal digit split that feeds the seg7 displays. It sits on the input side of the CPU board, turning switch/keypad decimal entry into operands for mips_cpu. A start/busy/done handshake makes it safe to drive from the divided CPU clock domain or the raw board clock.

## Interface
- DIGITS, 4, number of BCD digits in bcd_in
- OUT_W, 16, binary output width; must satisfy 2^OUT_W > 10^DIGITS - 1
- clk  input  1  system clock, rising-edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request conversion; sampled only in IDLE
- bcd_in  input  4*DIGITS  packed BCD operand, digit DIGITS-1 in the MS nibble
- busy  output  1  high whenever the FSM is not in IDLE
- done  output  1  one-cycle pulse; result/err valid in that cycle
- err  output  1  last accepted operand contained a nibble > 9
- bin_out  output  OUT_W  binary result; holds until the next completion

## Operation
- Reset (rst=1 at a rising edge) forces the following; rst has priority over every other input:
  - state=IDLE
  - busy=0, done=0, err=0
  - bin_out=0, internal accumulator=0, digit counter=0
- FSM states: IDLE, CONV, DONE.
- IDLE with start=1 accepts the request:
  - captures bcd_in into a shift register, clears the accumulator and counter, clears err
  - if any nibble > 9: set err=1, bin_out<=0, go to DONE (no CONV cycles)
  - otherwise go to CONV
- CONV, once per cycle:
  - acc <= acc*10 + top nibble of the shift register, with acc*10 formed as (acc<<3)+(acc<<1) in OUT_W bits
  - shift register <= shift left by 4
  - counter increments
- On the CONV cycle with counter == DIGITS-1: bin_out <= new acc value, go to DONE.
- DONE: done=1 (Moore output) for exactly one cycle, then unconditionally go to IDLE.
- start is ignored in CONV and DONE. bcd_in changes after acceptance do not affect the result.
- Holding start high continuously produces back-to-back conversions, each re-sampling bcd_in in IDLE.
- Arithmetic is modulo 2^OUT_W. Given the parameter constraint, valid input never overflows.
- Reset mid-conversion aborts it: no done pulse, bin_out returns to 0.

## Timing
- Accept edge = edge E where state=IDLE and start=1.
- Valid operand:
  - busy=1 from cycle after E
  - done=1 and bin_out valid in the cycle after edge E+DIGITS, i.e. DIGITS+1 cycles of latency
  - busy=0 the following cycle
- Invalid operand: done=1, err=1, bin_out=0 in the cycle after E (latency 1).
- Throughput with start held high: one conversion per DIGITS+2 cycles (valid) or 2 cycles (invalid).
- err and bin_out are registered and stable between done pulses.
- There is no combinational path from any input to any output.

## Structure
- Shared package bcd_pkg: state enum (IDLE, CONV, DONE); constant BCD_NIBBLE=4; function checking a packed vector for any nibble > 9.
- One natural sub-module: mul10_add, combinational, (acc, digit) -> acc*10+digit at OUT_W bits. Everything else is inline in bcd_to_bin.
- Counter width is clog2(DIGITS). The shift register is 4*DIGITS bits.

## Test plan
- Reset, then start with bcd_in=0x1234 -> done in cycle 5 after accept, bin_out=1234 (0x04D2), err=0, busy high for cycles 1-5.
- bcd_in=0x9999 -> bin_out=9999 (0x270F); then bcd_in=0x0000 -> bin_out=0, confirming the previous value held until the new done.
- bcd_in=0x12A4 -> done in cycle 1 after accept, err=1, bin_out=0. Next valid 0x0042 -> err=0, bin_out=42.
- Accept 0x5678, assert rst for one cycle two cycles later -> no done, busy=0, bin_out=0. Then start 0x0042 -> bin_out=42.
- start held high, bcd_in=0x0507 toggled to 0x9999 during every CONV phase -> done every 6 cycles, each result = value present at accept edge.
- start and rst asserted together in IDLE -> stays IDLE, busy=0, no done next cycle.
